// File: rtl/fetch_gshare.sv
// Single-outstanding instruction fetch unit with a gshare direction predictor.
// The predictor is built only when FETCH_GSHARE_BP_EN is defined; otherwise conditional branches fall through.
module fetch_gshare #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          GHR_BITS = 4,
  parameter int          BHT_IDX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fq_full,
  input  logic        branch_mispredict,
  input  logic [31:0] new_fetch_pc,
  input  logic [63:0] new_fetch_order,
  input  logic        br_update,
  input  logic [31:0] br_pc,
  input  logic        br_taken,
  input  logic [31:0] ufp_rdata,
  input  logic        ufp_resp,
  output logic [31:0] ufp_addr,
  output logic [3:0]  ufp_rmask,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [63:0] out_order,
  output logic        out_pred_taken,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] order_q, order_d;

  logic [6:0]  opcode;
  logic        is_br, is_jal, pred_br, take;
  logic [31:0] b_imm, j_imm, next_pc;
  logic        issue, deliver;

  assign opcode  = ufp_rdata[6:0];
  assign is_br   = (opcode == 7'b1100011);
  assign is_jal  = (opcode == 7'b1101111);
  assign b_imm   = {{20{ufp_rdata[31]}}, ufp_rdata[7], ufp_rdata[30:25], ufp_rdata[11:8], 1'b0};
  assign j_imm   = {{12{ufp_rdata[31]}}, ufp_rdata[19:12], ufp_rdata[20], ufp_rdata[30:21], 1'b0};
  assign take    = is_jal | (is_br & pred_br);
  assign next_pc = pc_q + (is_jal ? j_imm : ((is_br && pred_br) ? b_imm : 32'd4));

`ifdef FETCH_GSHARE_BP_EN
  localparam int BHT_N = 1 << BHT_IDX;

  logic [1:0]          bht_q [BHT_N];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS:0]   ghr_shift;
  logic [BHT_IDX-1:0]  ghr_ext, lk_idx, up_idx;
  logic                unused_br_pc;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = ghr_q;
  end

  assign ghr_shift    = {ghr_q, br_taken};
  assign lk_idx       = pc_q[BHT_IDX+1:2] ^ ghr_ext;
  assign up_idx       = br_pc[BHT_IDX+1:2] ^ ghr_ext;
  // Lookup reads the registered table, so a same-cycle update to the same entry is not seen.
  assign pred_br      = bht_q[lk_idx][1];
  assign unused_br_pc = ^{br_pc[31:BHT_IDX+2], br_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (br_update) begin
      if (br_taken && bht_q[up_idx] != 2'b11) bht_q[up_idx] <= bht_q[up_idx] + 2'b01;
      else if (!br_taken && bht_q[up_idx] != 2'b00) bht_q[up_idx] <= bht_q[up_idx] - 2'b01;
      ghr_q <= ghr_shift[GHR_BITS-1:0];
    end
  end
`else
  logic unused_bp;
  assign pred_br   = 1'b0;
  assign unused_bp = ^{br_update, br_pc, br_taken};
`endif

  assign deliver = rst && (state_q == S_WAIT) && ufp_resp && !branch_mispredict;
  assign issue   = rst && !branch_mispredict && !fq_full &&
                   ((state_q == S_IDLE) || ((state_q == S_WAIT) && ufp_resp));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    order_d = order_q;
    case (state_q)
      S_IDLE: begin
        if (branch_mispredict) begin
          pc_d    = new_fetch_pc;
          order_d = new_fetch_order + 64'd1;
        end else if (!fq_full) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_mispredict) begin
          pc_d    = new_fetch_pc;
          order_d = new_fetch_order + 64'd1;
          state_d = ufp_resp ? S_IDLE : S_SQUASH;
        end else if (ufp_resp) begin
          pc_d    = next_pc;
          order_d = order_q + 64'd1;
          state_d = fq_full ? S_IDLE : S_WAIT;
        end
      end
      S_SQUASH: begin
        if (branch_mispredict) begin
          pc_d    = new_fetch_pc;
          order_d = new_fetch_order + 64'd1;
        end
        if (ufp_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      order_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      order_q <= order_d;
    end
  end

  // Outputs are forced to zero while reset is held, even though pc_q sits at RESET_PC.
  assign ufp_rmask      = issue ? 4'hF : 4'h0;
  assign ufp_addr       = !rst ? 32'd0 : (deliver ? next_pc : pc_q);
  assign out_valid      = deliver;
  assign out_inst       = deliver ? ufp_rdata : 32'd0;
  assign out_pc         = deliver ? pc_q : 32'd0;
  assign out_order      = deliver ? order_q : 64'd0;
  assign out_pred_taken = deliver & take;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_gshare.sv
// Directed table-driven bench for fetch_gshare; predictor checks adapt to FETCH_GSHARE_BP_EN.
module tb_fetch_gshare;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_SQ = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fq_full, branch_mispredict, br_update, br_taken, ufp_resp;
  logic [31:0] new_fetch_pc, br_pc, ufp_rdata;
  logic [63:0] new_fetch_order;
  logic [31:0] ufp_addr, out_inst, out_pc;
  logic [3:0]  ufp_rmask;
  logic        out_valid, out_pred_taken;
  logic [63:0] out_order;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        fq;
    logic        mp;
    logic [31:0] npc;
    logic [63:0] nord;
    logic        resp;
    logic [31:0] rdata;
    logic [1:0]  e_state;
    logic        e_iss;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [63:0] e_ord;
    logic        e_pred;
  } vec_t;

  vec_t vecs[$];

  fetch_gshare dut (
    .clk(clk), .rst(rst), .fq_full(fq_full), .branch_mispredict(branch_mispredict),
    .new_fetch_pc(new_fetch_pc), .new_fetch_order(new_fetch_order),
    .br_update(br_update), .br_pc(br_pc), .br_taken(br_taken),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_order(out_order),
    .out_pred_taken(out_pred_taken), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every delivered instruction must match the next expected order.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got order %h want no delivery", out_order);
      end else begin
        chk("sb_order", out_order, exp_q.pop_front());
      end
    end
  end

  function automatic vec_t v(logic fq, logic mp, logic [31:0] npc, logic [63:0] nord,
                             logic resp, logic [31:0] rd, logic [1:0] st, logic iss,
                             logic [31:0] addr, logic val, logic [31:0] pc,
                             logic [63:0] ord, logic pred);
    vec_t r;
    r.fq = fq; r.mp = mp; r.npc = npc; r.nord = nord; r.resp = resp; r.rdata = rd;
    r.e_state = st; r.e_iss = iss; r.e_addr = addr; r.e_val = val; r.e_pc = pc;
    r.e_ord = ord; r.e_pred = pred;
    return r;
  endfunction

  // Driver: inputs change 1 time unit after posedge, outputs sampled at negedge.
  task automatic idle_inputs();
    fq_full = 1'b0; branch_mispredict = 1'b0; new_fetch_pc = '0; new_fetch_order = '0;
    br_update = 1'b0; br_pc = '0; br_taken = 1'b0; ufp_rdata = '0; ufp_resp = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(int i, vec_t r);
    fq_full = r.fq; branch_mispredict = r.mp; new_fetch_pc = r.npc; new_fetch_order = r.nord;
    ufp_resp = r.resp; ufp_rdata = r.rdata;
    @(negedge clk);
    chk($sformatf("r%0d_state", i), 64'(dbg_state), 64'(r.e_state));
    chk($sformatf("r%0d_rmask", i), 64'(ufp_rmask), r.e_iss ? 64'hF : 64'h0);
    if (r.e_iss) chk($sformatf("r%0d_addr", i), 64'(ufp_addr), 64'(r.e_addr));
    chk($sformatf("r%0d_valid", i), 64'(out_valid), 64'(r.e_val));
    if (r.e_val) begin
      chk($sformatf("r%0d_pc", i), 64'(out_pc), 64'(r.e_pc));
      chk($sformatf("r%0d_order", i), out_order, r.e_ord);
      chk($sformatf("r%0d_inst", i), 64'(out_inst), 64'(r.rdata));
      chk($sformatf("r%0d_pred", i), 64'(out_pred_taken), 64'(r.e_pred));
    end
    next_cycle();
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    chk({tag, "_rmask"}, 64'(ufp_rmask), 64'h0);
    chk({tag, "_addr"}, 64'(ufp_addr), 64'h0);
    chk({tag, "_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_outs"}, {out_inst, out_pc} | out_order | 64'(out_pred_taken), 64'h0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    logic        bp_en;
    logic [31:0] beq_next;
`ifdef FETCH_GSHARE_BP_EN
    bp_en = 1'b1;
`else
    bp_en = 1'b0;
`endif
    beq_next = bp_en ? 32'h1eceb020 : 32'h1eceb014;

    //     fq mp npc           nord  resp rdata         state    iss addr          val pc            ord  pred
    vecs.push_back(v(0, 0, 32'h0,        0,  0, 32'h0,        ST_IDLE, 1, 32'h1eceb000, 0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000013, ST_WAIT, 1, 32'h1eceb004, 1, 32'h1eceb000, 0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  0, 32'h0,        ST_WAIT, 0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000013, ST_WAIT, 1, 32'h1eceb008, 1, 32'h1eceb004, 1,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'hff9ff06f, ST_WAIT, 1, 32'h1eceb000, 1, 32'h1eceb008, 2,  1));
    vecs.push_back(v(1, 0, 32'h0,        0,  1, 32'h00000013, ST_WAIT, 0, 32'h0,        1, 32'h1eceb000, 3,  0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(1, 0, 32'h0,      0,  0, 32'h0,        ST_IDLE, 0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  0, 32'h0,        ST_IDLE, 1, 32'h1eceb004, 0, 32'h0,        0,  0));
    vecs.push_back(v(0, 1, 32'h1eceb100, 9,  0, 32'h0,        ST_WAIT, 0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000013, ST_SQ,   0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  0, 32'h0,        ST_IDLE, 1, 32'h1eceb100, 0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000013, ST_WAIT, 1, 32'h1eceb104, 1, 32'h1eceb100, 10, 0));
    vecs.push_back(v(0, 1, 32'h1eceb200, 20, 1, 32'h00000013, ST_WAIT, 0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 1, 32'h1eceb300, 30, 0, 32'h0,        ST_IDLE, 0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  0, 32'h0,        ST_IDLE, 1, 32'h1eceb300, 0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000863, ST_WAIT, 1, 32'h1eceb304, 1, 32'h1eceb300, 31, 0));
    vecs.push_back(v(0, 1, 32'h1eceb400, 40, 0, 32'h0,        ST_WAIT, 0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 1, 32'h1eceb500, 50, 0, 32'h0,        ST_SQ,   0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000013, ST_SQ,   0, 32'h0,        0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  0, 32'h0,        ST_IDLE, 1, 32'h1eceb500, 0, 32'h0,        0,  0));
    vecs.push_back(v(0, 0, 32'h0,        0,  1, 32'h00000013, ST_WAIT, 1, 32'h1eceb504, 1, 32'h1eceb500, 51, 0));

    foreach (vecs[i]) if (vecs[i].e_val) exp_q.push_back(vecs[i].e_ord);

    // Reset with a response pending: all outputs must read zero.
    rst = 1'b0;
    idle_inputs();
    ufp_resp = 1'b1;
    ufp_rdata = 32'h00000013;
    #1;
    next_cycle();
    check_reset_outputs("rst0");
    next_cycle();
    rst = 1'b1;
    ufp_resp = 1'b0;
    ufp_rdata = '0;

    foreach (vecs[i]) run_row(i, vecs[i]);

    // Reset during an outstanding request, then a stray response right after release.
    rst = 1'b0;
    idle_inputs();
    check_reset_outputs("rst1");
    next_cycle();
    rst = 1'b1;
    ufp_resp = 1'b1;
    ufp_rdata = 32'h00000013;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    chk("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("post_rst_rmask", 64'(ufp_rmask), 64'hF);
    chk("post_rst_addr", 64'(ufp_addr), 64'h1eceb000);
    next_cycle();

    // Train the predictor with fetch blocked, then fetch a BEQ +16 at 0x1eceb010.
    rst = 1'b0;
    idle_inputs();
    fq_full = 1'b1;
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      br_update = 1'b1;
      br_taken  = 1'b1;
      br_pc     = (k < 4) ? 32'h1eceb040 : 32'h1eceb010;
      @(negedge clk);
      chk($sformatf("train%0d_rmask", k), 64'(ufp_rmask), 64'h0);
      next_cycle();
    end
    br_update = 1'b0;
    branch_mispredict = 1'b1;
    new_fetch_pc = 32'h1eceb010;
    new_fetch_order = 64'd99;
    @(negedge clk);
    chk("redir_rmask", 64'(ufp_rmask), 64'h0);
    next_cycle();
    branch_mispredict = 1'b0;
    fq_full = 1'b0;
    @(negedge clk);
    chk("beq_iss_rmask", 64'(ufp_rmask), 64'hF);
    chk("beq_iss_addr", 64'(ufp_addr), 64'h1eceb010);
    next_cycle();
    exp_q.push_back(64'd100);
    ufp_resp = 1'b1;
    ufp_rdata = 32'h00000863;
    @(negedge clk);
    chk("beq_valid", 64'(out_valid), 64'h1);
    chk("beq_pc", 64'(out_pc), 64'h1eceb010);
    chk("beq_pred", 64'(out_pred_taken), 64'(bp_en));
    chk("beq_next_addr", 64'(ufp_addr), 64'(beq_next));
    next_cycle();
    idle_inputs();
    next_cycle();

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_gshare.md
FETCH_GSHARE -- requirements
Module: fetch_gshare

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  RESET_PC  32'h1eceb000  PC loaded at reset
  GHR_BITS  4  global history width, 1..10
  BHT_IDX   8  log2 of counter-table entries; BHT_IDX >= GHR_BITS
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-low reset
  fq_full  in  1  fetch queue cannot accept
  branch_mispredict  in  1  redirect request
  new_fetch_pc  in  32  redirect target
  new_fetch_order  in  64  order of the mispredicting instruction
  br_update  in  1  resolved conditional branch strobe
  br_pc  in  32  PC of the resolved branch
  br_taken  in  1  resolved direction
  ufp_rdata  in  32  instruction word
  ufp_resp  in  1  memory response valid
  ufp_addr  out  32  memory request address
  ufp_rmask  out  4  request strobe, 4'hF = read
  out_valid  out  1  instruction delivered this cycle
  out_inst  out  32  delivered instruction
  out_pc  out  32  delivered PC
  out_order  out  64  delivered order
  out_pred_taken  out  1  prediction attached to the instruction

Function
REQ-003 States: IDLE (no request outstanding), WAIT (one outstanding), SQUASH (outstanding, response to be discarded); at most one request outstanding.
REQ-004 Issue: ufp_rmask=4'hF iff (IDLE, !fq_full, !branch_mispredict) or (WAIT, ufp_resp, !branch_mispredict, !fq_full); otherwise 4'h0.
REQ-005 ufp_addr: pc_reg in IDLE; the computed next PC in WAIT on response (same-cycle back-to-back issue).
REQ-006 IDLE: issue -> WAIT; branch_mispredict -> pc_reg=new_fetch_pc, order_reg=new_fetch_order+1, no issue, stay IDLE.
REQ-007 WAIT with ufp_resp and no mispredict: out_valid=1, out_inst=ufp_rdata, out_pc=pc_reg, out_order=order_reg; pc_reg=next PC; order_reg+=1; -> WAIT if issued, else IDLE.
REQ-008 WAIT with branch_mispredict and no response: -> SQUASH, redirect per REQ-006; with a same-cycle response: response dropped (out_valid=0), redirect, -> IDLE.
REQ-009 SQUASH: ufp_resp -> IDLE, out_valid=0; a further branch_mispredict overwrites pc_reg/order_reg again.
REQ-010 Next PC: opcode 7'b1100011 and predicted taken -> pc_reg+B-immediate (sign-extended, bit0=0); opcode 7'b1101111 -> pc_reg+J-immediate; otherwise pc_reg+4; all modulo 2^32.
REQ-011 Index = pc[BHT_IDX+1:2] XOR zero-extended GHR; prediction taken iff counter[idx][1]=1; out_pred_taken=1 for taken branch or JAL, else 0.
REQ-012 Update on br_update: index from br_pc and current GHR; 2-bit counter saturating +1 if br_taken, -1 otherwise (3 and 0 hold); then GHR={GHR[GHR_BITS-2:0],br_taken}, effective next cycle.
REQ-013 Same-cycle lookup and update to one index: lookup uses the pre-update counter.
REQ-014 br_update is independent of fetch state and of branch_mispredict.

Reset
REQ-015 While rst=0: state=IDLE, pc_reg=RESET_PC, order_reg=0, GHR=0, all counters=2'b01, ufp_rmask=0, out_valid=0, other outputs 0.
REQ-016 Reset asserted mid-request aborts it; a response arriving in the first cycle after release is ignored (IDLE).

Configuration
REQ-017 FETCH_GSHARE_BP_EN defined: behaviour per REQ-011..013.
REQ-018 FETCH_GSHARE_BP_EN undefined: no table or GHR; conditional branches predicted not-taken; JAL still redirected; br_update ignored.

Verification
REQ-019 Reset release, fq_full=0 -> first cycle ufp_addr=0x1eceb000, ufp_rmask=4'hF.
REQ-020 Response 0x00000013 at 0x1eceb000 -> out_valid=1, out_order=0, same-cycle ufp_addr=0x1eceb004.
REQ-021 Four br_update taken at PC 0x1eceb010, then fetch BEQ imm +16 there -> out_pred_taken=1, next ufp_addr=0x1eceb020 (with BP_EN).
REQ-022 Mispredict to 0x1eceb100, order 9, during WAIT -> stale response dropped, next request 0x1eceb100, next out_order=10.
REQ-023 JAL imm -8 at 0x1eceb008 -> next ufp_addr=0x1eceb000, out_pred_taken=1, both configurations.
REQ-024 fq_full held 5 cycles after a response -> ufp_rmask=0 throughout, IDLE, issue on the cycle fq_full drops.
